// File: rtl/game_timer_pkg.sv
// ---------------------------------------------------------------------------
// game_timer_pkg
//
// Shared definitions for the game-round countdown controller.
//   - State encodings (ST_*) and the matching enum used by the FSM.
//   - BCD digit constants.
//   - Small BCD helpers used by the digit register and the top level.
// ---------------------------------------------------------------------------
package game_timer_pkg;

    // FSM state encodings. These values appear on the State debug port,
    // so they are fixed rather than left to the synthesis tool.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_PAUSED = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

    typedef enum logic [1:0] {
        STATE_IDLE   = ST_IDLE,
        STATE_RUN    = ST_RUN,
        STATE_PAUSED = ST_PAUSED,
        STATE_DONE   = ST_DONE
    } state_e;

    // BCD digit limits.
    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_NINE = 4'd9;

    // One-digit BCD decrement with wrap: 0 -> 9, otherwise d - 1.
    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        logic [3:0] r;
        if (d == BCD_ZERO) begin
            r = BCD_NINE;
        end else begin
            r = d - 4'd1;
        end
        return r;
    endfunction

    // Maps an integer parameter onto a legal BCD digit. Out-of-range values
    // saturate at 9 so the displays never see a non-decimal code.
    function automatic logic [3:0] bcd_clamp(input int unsigned v);
        logic [3:0] r;
        if (v > 32'd9) begin
            r = BCD_NINE;
        end else begin
            r = 4'(v);
        end
        return r;
    endfunction

endpackage : game_timer_pkg

// File: rtl/bcd_down_digit.sv
// ---------------------------------------------------------------------------
// bcd_down_digit
//
// One BCD digit register with synchronous load and decrement.
//
// Ports:
//   clk        in   1  clock, all logic on posedge
//   rst        in   1  synchronous active-high reset
//   rst_value  in   4  digit value taken while rst is high
//   load       in   1  load load_value this cycle (priority over dec)
//   load_value in   4  value to load
//   dec        in   1  decrement this cycle (9 follows 0)
//   digit      out  4  current registered digit
//   borrow     out  1  combinational: dec is high while the digit is 0,
//                      i.e. the next-higher digit must decrement too
// ---------------------------------------------------------------------------
module bcd_down_digit
    import game_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rst_value,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic [3:0] digit,
    output logic       borrow
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_value;
        end else if (dec) begin
            digit_d = bcd_dec(digit_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= rst_value;
        end else begin
            digit_q <= digit_d;
        end
    end

    // A load overrides a decrement, so no borrow is propagated on a load.
    assign borrow = dec && !load && (digit_q == BCD_ZERO);
    assign digit  = digit_q;

endmodule : bcd_down_digit

// File: rtl/round_countdown.sv
// ---------------------------------------------------------------------------
// round_countdown
//
// Game-round countdown controller. Holds remaining play time as two BCD
// digits (tens:ones), decrements once per Tick while a round is running and
// pulses TimeUp when the count reaches 00.
//
// Parameters:
//   START_TENS  tens digit loaded at round start (0..9)
//   START_ONES  ones digit loaded at round start (0..9)
//
// Ports:
//   ClockIn    in   1  system clock, all logic on posedge
//   Reset      in   1  synchronous active-high reset, priority over all
//   Start      in   1  single-cycle request to begin a round (IDLE/DONE only)
//   Pause      in   1  level; holds the countdown while high (RUN/PAUSED)
//   Tick       in   1  single-cycle one-second enable from the rate divider
//   OnesValue  out  4  BCD ones digit of remaining seconds
//   TensValue  out  4  BCD tens digit of remaining seconds
//   Active     out  1  high in RUN and PAUSED
//   TimeUp     out  1  registered one-cycle pulse on entry to DONE
//   State      out  2  current FSM state (IDLE=00 RUN=01 PAUSED=10 DONE=11)
//
// Strobe semantics: Start and Tick carry no handshake. Each is consumed on
// the edge where it is sampled high; if the current state does not accept
// it, it is dropped, never held or queued. Pause is a level.
// ---------------------------------------------------------------------------
module round_countdown
    import game_timer_pkg::*;
#(
    parameter int unsigned START_TENS = 6,
    parameter int unsigned START_ONES = 0
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Tick,
    output logic [3:0] OnesValue,
    output logic [3:0] TensValue,
    output logic       Active,
    output logic       TimeUp,
    output logic [1:0] State
);

    localparam logic [3:0] START_TENS_BCD = bcd_clamp(START_TENS);
    localparam logic [3:0] START_ONES_BCD = bcd_clamp(START_ONES);

    // A 00 start value has nothing to count: Start goes straight to DONE.
    localparam bit START_IS_ZERO = (START_TENS_BCD == BCD_ZERO) &&
                                   (START_ONES_BCD == BCD_ZERO);

    state_e     state_q;
    state_e     state_d;
    logic       time_up_q;
    logic       time_up_d;

    logic       load;
    logic       dec_ones;
    logic       ones_borrow;
    logic       unused_tens_borrow;
    logic [3:0] ones_value;
    logic [3:0] tens_value;
    logic       at_zero;
    logic       at_one;

    assign at_zero = (tens_value == BCD_ZERO) && (ones_value == BCD_ZERO);
    assign at_one  = (tens_value == BCD_ZERO) && (ones_value == 4'd1);

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        time_up_d = 1'b0;
        load      = 1'b0;
        dec_ones  = 1'b0;

        case (state_q)
            // IDLE and DONE behave the same way: only Start matters, and it
            // takes priority over a coincident Tick (no decrement on load).
            STATE_IDLE, STATE_DONE: begin
                if (Start) begin
                    load = 1'b1;
                    if (START_IS_ZERO) begin
                        state_d   = STATE_DONE;
                        time_up_d = 1'b1;
                    end else begin
                        state_d = STATE_RUN;
                    end
                end
            end

            STATE_RUN: begin
                // Pause beats Tick; the tick in that cycle is lost.
                if (Pause) begin
                    state_d = STATE_PAUSED;
                end else if (Tick && !at_zero) begin
                    dec_ones = 1'b1;
                    if (at_one) begin
                        state_d   = STATE_DONE;
                        time_up_d = 1'b1;
                    end
                end
            end

            STATE_PAUSED: begin
                // Leaving PAUSED never decrements, even with a Tick present.
                if (!Pause) begin
                    state_d = STATE_RUN;
                end
            end

            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q   <= STATE_IDLE;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_up_q <= time_up_d;
        end
    end

    // -----------------------------------------------------------------------
    // Digit registers: the ones borrow drives the tens decrement.
    // -----------------------------------------------------------------------
    bcd_down_digit u_ones (
        .clk        (ClockIn),
        .rst        (Reset),
        .rst_value  (START_ONES_BCD),
        .load       (load),
        .load_value (START_ONES_BCD),
        .dec        (dec_ones),
        .digit      (ones_value),
        .borrow     (ones_borrow)
    );

    // The tens digit can never borrow: the FSM leaves RUN at 00:01 and does
    // not decrement at 00:00, so its borrow output is intentionally sunk.
    bcd_down_digit u_tens (
        .clk        (ClockIn),
        .rst        (Reset),
        .rst_value  (START_TENS_BCD),
        .load       (load),
        .load_value (START_TENS_BCD),
        .dec        (ones_borrow),
        .digit      (tens_value),
        .borrow     (unused_tens_borrow)
    );

    assign OnesValue = ones_value;
    assign TensValue = tens_value;
    assign State     = state_q;
    assign Active    = (state_q == STATE_RUN) || (state_q == STATE_PAUSED);
    assign TimeUp    = time_up_q;

endmodule : round_countdown

// File: doc/round_countdown.md
# round_countdown

Game-round countdown controller: holds remaining play time as two BCD digits, decrements once per 1 Hz tick while a round is running, and flags time-up. Sits directly downstream of the 1 Hz rate divider, which supplies `Tick`, and directly upstream of the two hex decoders, which display `OnesValue` and `TensValue`. `Active` and `TimeUp` drive the game logic, gating mole spawning and score freeze.

## Interface
Parameters:
- `START_TENS`, default 6: tens digit loaded at round start; legal range 0–9.
- `START_ONES`, default 0: ones digit loaded at round start; legal range 0–9.

Ports:
- `ClockIn`  in  1  system clock (50 MHz); all logic on posedge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  single-cycle request to begin or restart a round.
- `Pause`  in  1  level; while high, the countdown holds.
- `Tick`  in  1  single-cycle enable, one per second, from the rate divider.
- `OnesValue`  out  4  BCD ones digit of remaining seconds.
- `TensValue`  out  4  BCD tens digit of remaining seconds.
- `Active`  out  1  high in RUN and PAUSED.
- `TimeUp`  out  1  one-cycle pulse when remaining time reaches 00.
- `State`  out  2  current FSM state, for debug and LEDs.

## Operation
- States and encodings: IDLE=00, RUN=01, PAUSED=10, DONE=11.
- IDLE:
  - Digits show START_TENS:START_ONES.
  - `Start` loads the start value and moves to RUN.
  - `Tick` and `Pause` are ignored.
- RUN:
  - `Pause`=1 moves to PAUSED.
  - Otherwise, on `Tick`, the digits decrement by one second using BCD borrow: ones 0 becomes 9 and tens decrements; otherwise ones decrements.
  - A decrement from 00:01 to 00:00 moves to DONE.
- PAUSED:
  - Digits hold.
  - `Pause`=0 returns to RUN.
  - Ticks are dropped, not queued.
- DONE:
  - Digits hold at 00.
  - `Start` reloads the start value and moves to RUN.
- `Start` in RUN or PAUSED is ignored; a round cannot be restarted mid-play without `Reset`.
- Start value 00:00: `Start` in IDLE or DONE goes directly to DONE and pulses `TimeUp`.
- Digits never go below 00 and never show values above 9.
- `Active` = (State==RUN) | (State==PAUSED).

## Timing
- Reset values: `OnesValue`=START_ONES, `TensValue`=START_TENS, `Active`=0, `TimeUp`=0, `State`=IDLE.
- `Reset` has priority over all inputs. Reset mid-round returns to IDLE at the next edge with no `TimeUp` pulse.
- Latency:
  - Input sampled at edge N; digits and state are updated after edge N and visible in cycle N+1.
  - `TimeUp` is registered and goes high in the same cycle that `State` becomes DONE and digits read 00, for exactly one cycle.
- Simultaneous events:
  - `Start`+`Tick` in IDLE or DONE: load wins; no decrement that cycle.
  - `Pause`+`Tick` in RUN: pause wins; the tick is lost.
  - `Pause` deassert + `Tick` in PAUSED: return to RUN; the tick is lost.
- Consecutive ticks on back-to-back cycles must each decrement; the block imposes no tick spacing.

## Structure
- Package `game_timer_pkg`:
  - state encoding localparams (`ST_IDLE`, `ST_RUN`, `ST_PAUSED`, `ST_DONE`);
  - BCD constants `BCD_ZERO`=4'd0 and `BCD_NINE`=4'd9.
- Sub-module `bcd_down_digit`:
  - one-digit register with load, decrement enable, and borrow-out (borrow when the digit is 0 and decrement is enabled);
  - instantiated twice, with the ones borrow-out gating the tens decrement.
- The FSM and the `TimeUp` register live in the top module.

## Test plan
- Reset, then hold 5 cycles -> digits 6/0, `Active`=0, `State`=00, `TimeUp`=0.
- `Start`, then 1 tick -> 5/9; 10 further ticks -> 4/9; all 60 ticks -> 0/0, `State`=11, one-cycle `TimeUp`, `Active`=0; further ticks leave the digits at 0/0.
- In RUN at 3/2, raise `Pause` and apply 5 ticks -> digits stay 3/2, `State`=10; drop `Pause` and apply 1 tick -> 3/1. `Pause`+`Tick` in the same cycle -> no decrement.
- `Start`+`Tick` in the same cycle from IDLE -> digits 6/0, `State`=01; the next tick gives 5/9. `Start` during RUN at 4/4 -> ignored, digits 4/4.
- `Reset` asserted in RUN at 0/1 in the same cycle as `Tick` -> IDLE with digits 6/0, `TimeUp` never pulses.
- Parameters START_TENS=0, START_ONES=0: `Start` -> `State`=11 next cycle, `TimeUp` one-cycle pulse, digits 0/0. Parameters 0/2: `Start`, then 2 ticks -> DONE.
